// File: rtl/bg_vram_arbiter.sv
// rtl/bg_vram_arbiter.sv - BG VRAM time-slot arbiter (video fetch + CPU req/ack); optional macro BG_VRAM_ARB_VBLANK_EN
module bg_vram_arbiter #(
  parameter int AW          = 10,
  parameter int DW          = 16,
  parameter int VSLOT       = 0,
  parameter int VBLANK_LINE = 224
) (
  input  logic          VCLK,
  input  logic          reset,
  input  logic [8:0]    HPOS,
  input  logic [8:0]    VPOS,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] bg_tile,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_READ,
    ST_ACK,
    ST_RELEASE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    w_ram_we;
  logic          w_cpu_ack;
  logic          w_vblank;
  logic          w_vid_slot;
  logic [4:0]    w_vid_col;
  logic [AW-1:0] w_vid_addr;
  logic          r_vid_pend;
  logic [DW-1:0] r_tile_next;
  logic [DW-1:0] r_bg_tile;
  logic [DW-1:0] r_cpu_rdata;
  logic          w_unused;

`ifdef BG_VRAM_ARB_VBLANK_EN
  // Video fetches stop during vertical blank, handing every cycle to the CPU.
  assign w_vblank = (VPOS >= 9'(VBLANK_LINE));
`else
  assign w_vblank = 1'b0;
`endif

  assign w_unused   = &{1'b0, HPOS[8], VPOS[8], VPOS[2:0]};
  assign w_vid_slot = (HPOS[2:0] == 3'(VSLOT)) && !w_vblank;

  // Fetch the tile one column ahead so it is ready at the next tile boundary.
  assign w_vid_col  = HPOS[7:3] + 5'd1;
  assign w_vid_addr = AW'({w_vid_col, VPOS[7:3]});

  assign ram_addr  = w_vid_slot ? w_vid_addr : cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = w_ram_we;
  assign cpu_ack   = w_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign bg_tile   = r_bg_tile;
  assign busy      = (r_state != ST_IDLE);

  // CPU handshake state register.
  always_ff @(posedge VCLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // CPU next-state and port strobes; the video slot always wins the port.
  always_comb begin
    w_state_next = r_state;
    w_ram_we     = 2'b00;
    w_cpu_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!w_vid_slot) begin
          if (cpu_we) begin
            w_ram_we     = cpu_be;
            w_state_next = ST_ACK;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        w_cpu_ack    = 1'b1;
        w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!cpu_req) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // An operation caught by reset must neither strobe the RAM nor complete.
    if (reset) begin
      w_ram_we  = 2'b00;
      w_cpu_ack = 1'b0;
    end
  end

  // Capture CPU read data the cycle after the read address was issued.
  always_ff @(posedge VCLK) begin
    if (reset)                  r_cpu_rdata <= '0;
    else if (r_state == ST_READ) r_cpu_rdata <= ram_rdata;
  end

  // Video pipeline: slot -> tile_next one cycle later -> bg_tile at tile boundary.
  always_ff @(posedge VCLK) begin
    if (reset) begin
      r_vid_pend  <= 1'b0;
      r_tile_next <= '0;
      r_bg_tile   <= '0;
    end else begin
      r_vid_pend <= w_vid_slot;
      if (r_vid_pend) r_tile_next <= ram_rdata;
      if ((HPOS[2:0] == 3'd7) && !w_vblank) r_bg_tile <= r_tile_next;
    end
  end

endmodule

// File: tb/tb_bg_vram_arbiter.sv
// tb/tb_bg_vram_arbiter.sv - self-checking bench for bg_vram_arbiter
module tb_bg_vram_arbiter;

  localparam int VSLOT = 0;

  logic        VCLK = 1'b0;
  logic        reset;
  logic [8:0]  HPOS, VPOS;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] bg_tile;
  logic        busy;

  bg_vram_arbiter #(.AW(10), .DW(16), .VSLOT(VSLOT), .VBLANK_LINE(224)) dut (
    .VCLK(VCLK), .reset(reset), .HPOS(HPOS), .VPOS(VPOS),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .bg_tile(bg_tile), .busy(busy)
  );

  always #5 VCLK = ~VCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 291 + 1799);
  endfunction

  function automatic logic [9:0] m_vaddr(input logic [8:0] h, input logic [8:0] v);
    logic [4:0] c;
    c = h[7:3] + 5'd1;
    return {c, v[7:3]};
  endfunction

  // VRAM environment: 1024 x 16, one-cycle read latency, byte strobes, backdoor load
  logic [15:0] vram [1024];
  logic        bd_init = 1'b0, bd_en = 1'b0;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;
  int          ram_wr_cnt = 0;

  always @(posedge VCLK) begin
    ram_rdata <= vram[ram_addr];
    if (bd_init) begin
      for (int i = 0; i < 1024; i++) vram[i] = init_val(i);
    end else begin
      if (bd_en) vram[bd_addr] = bd_data;
      if (ram_we != 2'b00) begin
        ram_wr_cnt++;
        if (ram_we[0]) vram[ram_addr][7:0]  = ram_wdata[7:0];
        if (ram_we[1]) vram[ram_addr][15:8] = ram_wdata[15:8];
      end
    end
  end

  // Free-running pixel counter
  initial begin
    HPOS = 9'd0;
    forever begin
      @(posedge VCLK);
      #1 HPOS = HPOS + 9'd1;
    end
  end

  // Behavioural model: golden memory plus the tile the video side must present
  logic [15:0] gmem [1024];
  logic        m_vbl;
  logic        m_pend = 1'b0;
  logic [15:0] m_pend_val = '0, m_next = '0, m_bg = '0;

  always_comb begin
`ifdef BG_VRAM_ARB_VBLANK_EN
    m_vbl = (VPOS >= 9'd224);
`else
    m_vbl = 1'b0;
`endif
  end

  // Tile fetched in a slot becomes visible after the following phase-7 edge
  always @(posedge VCLK) begin
    logic [15:0] old_next;
    if (reset) begin
      m_pend = 1'b0; m_next = '0; m_bg = '0;
    end else begin
      old_next = m_next;
      if (m_pend) m_next = m_pend_val;
      if (HPOS[2:0] == 3'd7 && !m_vbl) m_bg = old_next;
      m_pend     = (HPOS[2:0] == 3'(VSLOT)) && !m_vbl;
      m_pend_val = gmem[m_vaddr(HPOS, VPOS)];
    end
  end

  // Compare process: tile output every cycle, port ownership on every video slot
  int         stb_cnt = 0;
  logic [1:0] stb_val = '0;

  always @(negedge VCLK) begin
    if (ram_we != 2'b00) begin
      stb_cnt++;
      stb_val = ram_we;
    end
    chk("bg_tile", bg_tile, m_bg);
    if (!reset && HPOS[2:0] == 3'(VSLOT) && !m_vbl) begin
      chk("vid_addr", ram_addr, m_vaddr(HPOS, VPOS));
      chk("vid_no_strobe", ram_we, 2'b00);
    end
  end

  task automatic step();
    @(posedge VCLK);
    #2;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    do begin step(); n++; end while (HPOS[2:0] != p && n < 16);
  endtask

  task automatic wait_hpos(input logic [8:0] h);
    int n = 0;
    do begin step(); n++; end while (HPOS != h && n < 1100);
    if (n >= 1100) chk("wait_hpos timeout", HPOS, h);
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    gmem[a] = d;
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    step();
    bd_en = 1'b0;
  endtask

  task automatic cpu_txn(input logic wr, input logic [1:0] be, input logic [9:0] addr,
                         input logic [15:0] wd, input string nm,
                         output int lat, output logic [15:0] rd);
    int          exp_lat;
    logic [2:0]  ip;
    logic [15:0] g;
    ip      = HPOS[2:0] + 3'd1;
    exp_lat = (wr ? 2 : 3) + ((ip == 3'(VSLOT) && !m_vbl) ? 1 : 0);
    stb_cnt = 0;
    cpu_req = 1'b1; cpu_we = wr; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    @(negedge VCLK);
    while (cpu_ack !== 1'b1 && lat < 16) begin
      step(); lat++;
      @(negedge VCLK);
    end
    chk({nm, " ack"}, cpu_ack, 1);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " busy"}, busy, 1);
    if (wr) begin
      g = gmem[addr];
      if (be[0]) g[7:0]  = wd[7:0];
      if (be[1]) g[15:8] = wd[15:8];
      gmem[addr] = g;
      chk({nm, " strobes"}, stb_cnt, (be != 2'b00) ? 1 : 0);
      if (be != 2'b00) chk({nm, " strobe value"}, stb_val, be);
    end else begin
      chk({nm, " rdata"}, cpu_rdata, gmem[addr]);
    end
    rd = cpu_rdata;
    step();
    cpu_req = 1'b0;
    @(negedge VCLK);
    chk({nm, " ack pulse"}, cpu_ack, 0);
    step();
    @(negedge VCLK);
    chk({nm, " idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wr0;
    logic [15:0] rd;
    for (int i = 0; i < 1024; i++) gmem[i] = init_val(i);
    reset = 1'b1; VPOS = 9'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    bd_init = 1'b1;
    step();
    bd_init = 1'b0;
    repeat (3) begin
      @(negedge VCLK);
      chk("rst cpu_ack", cpu_ack, 0);
      chk("rst cpu_rdata", cpu_rdata, 16'h0000);
      chk("rst bg_tile", bg_tile, 16'h0000);
      chk("rst busy", busy, 0);
      chk("rst ram_we", ram_we, 2'b00);
      step();
    end
    reset = 1'b0;

    // Reset held 3 cycles while a write sits in ISSUE
    wait_phase(3'd2);
    wr0 = ram_wr_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 10'h155; cpu_wdata = 16'h1111;
    step();
    reset = 1'b1; cpu_req = 1'b0;
    repeat (3) begin
      @(negedge VCLK);
      chk("midrst ack", cpu_ack, 0);
      chk("midrst ram_we", ram_we, 2'b00);
      step();
    end
    reset = 1'b0;
    @(negedge VCLK);
    chk("midrst busy", busy, 0);
    chk("midrst bg_tile", bg_tile, 16'h0000);
    chk("midrst no write", ram_wr_cnt - wr0, 0);
    chk("midrst mem", vram[10'h155], gmem[10'h155]);

    // Write then read back, no stall
    wait_phase(3'd2);
    cpu_txn(1'b1, 2'b11, 10'h155, 16'hA5C3, "wr155", lat, rd);
    chk("wr155 lat literal", lat, 2);
    wait_phase(3'd2);
    cpu_txn(1'b0, 2'b11, 10'h155, 16'h0000, "rd155", lat, rd);
    chk("rd155 lat literal", lat, 3);
    chk("rd155 data literal", rd, 16'hA5C3);

    // Read whose ISSUE lands on the video slot
    wait_phase(3'(VSLOT - 1));
    cpu_txn(1'b0, 2'b11, 10'h155, 16'h0000, "rdstall", lat, rd);
    chk("rdstall lat literal", lat, 4);
    chk("rdstall data literal", rd, 16'hA5C3);

    // Byte-enable writes
    preload(10'h0A7, 16'h1234);
    wait_phase(3'd3);
    cpu_txn(1'b1, 2'b01, 10'h0A7, 16'hFFFF, "wrbe01", lat, rd);
    wait_phase(3'd4);
    cpu_txn(1'b0, 2'b11, 10'h0A7, 16'h0000, "rdbe01", lat, rd);
    chk("rdbe01 literal", rd, 16'h12FF);
    wait_phase(3'd5);
    cpu_txn(1'b1, 2'b00, 10'h0A7, 16'h0000, "wrbe00", lat, rd);
    wait_phase(3'd1);
    cpu_txn(1'b0, 2'b11, 10'h0A7, 16'h0000, "rdbe00", lat, rd);
    chk("rdbe00 literal", rd, 16'h12FF);

    // Tile fetch and column wrap on row 3
    preload(10'h083, 16'hBEEF);
    preload(10'h003, 16'hC0DE);
    VPOS = 9'd24;
    wait_hpos(9'd0);
    wait_hpos(9'd32);
    @(negedge VCLK);
    chk("tile hpos32 literal", bg_tile, 16'hBEEF);
    wait_hpos(9'd39);
    @(negedge VCLK);
    chk("tile hpos39 literal", bg_tile, 16'hBEEF);
    wait_hpos(9'd256);
    @(negedge VCLK);
    chk("tile wrap literal", bg_tile, 16'hC0DE);

    // Reads at every phase during vertical blank
    VPOS = 9'd230;
    for (int p = 0; p < 8; p++) begin
      wait_phase(3'(p));
      cpu_txn(1'b0, 2'b11, 10'h155, 16'h0000, "vblank rd", lat, rd);
      if (p == (VSLOT + 7) % 8) begin
`ifdef BG_VRAM_ARB_VBLANK_EN
        chk("vblank no stall literal", lat, 3);
`else
        chk("vblank stall literal", lat, 4);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bg_vram_arbiter.md
Name: bg_vram_arbiter

Overview:
Time-slot arbiter sharing one single-port BG VRAM (1024 x 16, 1-cycle read latency) between the BG scanline fetch and the 68000 bus side.
- Video gets one fixed slot per 8-pixel tile.
- The CPU gets all other cycles through a req/ack handshake, which replaces the dual-port BG VRAM.
- Sits between the video RAM block and the BG scanline generator, inside the video top level.

Parameters:
AW, 10, VRAM word address width
DW, 16, VRAM data width
VSLOT, 0, HPOS[2:0] value at which the video fetch owns the port
VBLANK_LINE, 224, first VPOS line of vertical blank (used by optional feature only)

Ports:
VCLK  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
HPOS  in  9  horizontal pixel position
VPOS  in  9  vertical line position
cpu_req  in  1  level request; held high until cpu_ack seen
cpu_we  in  1  1=write, 0=read; stable while cpu_req high
cpu_be  in  2  byte enables {upper,lower}; stable while cpu_req high
cpu_addr  in  AW  word address; stable while cpu_req high
cpu_wdata  in  DW  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid from cpu_ack until next read completes
ram_addr  out  AW  VRAM address
ram_we  out  2  per-byte write strobes
ram_wdata  out  DW  VRAM write data
ram_rdata  in  DW  VRAM read data, valid one cycle after address
bg_tile  out  DW  tile word for current tile, updated at tile boundary
busy  out  1  1 when state != IDLE

Behaviour:
- Reset values: state IDLE; cpu_ack=0; cpu_rdata=0; bg_tile=0; busy=0; ram_we=0. ram_addr/ram_wdata are don't-care but never strobed.
- Video slot: when HPOS[2:0]==VSLOT:
  - ram_addr={HPOS[7:3]+1 (5-bit wrap), VPOS[7:3]}; ram_we=0.
  - Next cycle: ram_rdata captured into tile_next.
  - On the edge where HPOS[2:0]==7: bg_tile<=tile_next.
  - Tile 31 fetch wraps to column 0.
- CPU FSM:
  - IDLE: cpu_req=1 -> ISSUE.
  - ISSUE, non-video cycle: drive ram_addr=cpu_addr. Writes: ram_we=cpu_be, ram_wdata=cpu_wdata. Then ->ACK for a write, ->READ for a read.
  - ISSUE, video-slot cycle: port not driven by CPU; stay in ISSUE (one-cycle stall).
  - READ: cpu_rdata<=ram_rdata -> ACK.
  - ACK: cpu_ack=1 for exactly one cycle -> RELEASE.
  - RELEASE: wait for cpu_req=0 -> IDLE. No new request is accepted until the previous one has dropped.
- Latency, req rise to cpu_ack high:
  - write: 2 cycles, or 3 with a stall;
  - read: 3 cycles, or 4 with a stall.
- A write with cpu_be=00 still completes and acks, with no RAM strobe.
- Video has absolute priority. No CPU strobe is ever asserted in a video-slot cycle.
- Simultaneous video slot and CPU in READ: legal. The read data for the CPU returns while the video address is issued, because the port is pipelined.
- Reset mid-operation: the FSM returns to IDLE immediately, with no ack and no pending write. The CPU must re-request.
- ram_we is a registered-free combinational decode of state/slot. ram_addr mux: video slot ? video : CPU.

Optional Feature:
Macro BG_VRAM_ARB_VBLANK_EN.
- Defined: while VPOS>=VBLANK_LINE, video slots are suppressed. The CPU may issue on every cycle, so ISSUE never stalls and bg_tile holds its value.
- Undefined: video slots occur on every line regardless of VPOS.

Test Plan:
- Reset held 3 cycles mid-write (state ISSUE) -> ram_we never asserted, cpu_ack=0, busy=0, bg_tile=0 after release.
- Write: cpu_req at HPOS[2:0]=2, addr 0x155, be=11, data 0xA5C3 -> ram_we=11 one cycle later, cpu_ack 2 cycles after req. Then read of 0x155 -> cpu_rdata=0xA5C3 with ack 3 cycles after req.
- Stall: read req arriving so that ISSUE falls at HPOS[2:0]=VSLOT -> ram_addr shows video address that cycle, ack 4 cycles after req, data correct.
- Byte write: be=01, data 0xFFFF over 0x1234 -> readback 0x12FF; be=00 -> ack, no strobe, data unchanged.
- Tile fetch: preload VRAM[{5'd4,5'd3}]=0xBEEF, VPOS=24 -> bg_tile=0xBEEF from the edge at HPOS=31 through HPOS=39. Preload column 0 -> wrap at column 31 fetches it.
- With BG_VRAM_ARB_VBLANK_EN and VPOS=230: back-to-back reads never stall (3-cycle latency at every HPOS phase). Without the macro, the stall still occurs.
